// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART transmit framer.
interface uart_tx_frame_if;
  logic       txStart;
  logic [7:0] txData;
  logic       parityEn;
  logic       parityOdd;
  logic       twoStop;
  logic       txd;
  logic       busy;
  logic       clrTxStartBit;
  logic       txDone;

  modport master (
    output txStart, txData, parityEn, parityOdd, twoStop,
    input  txd, busy, clrTxStartBit, txDone
  );

  modport slave (
    input  txStart, txData, parityEn, parityOdd, twoStop,
    output txd, busy, clrTxStartBit, txDone
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity,
// 1 or 2 stop bits, each bit held CLKS_PER_BIT clocks. All outputs are registered.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;

  logic [7:0]       r_shadow;
  logic             r_par_en;
  logic             r_par_odd;
  logic             r_two_stop;

  logic             r_txd;
  logic             r_busy;
  logic             r_clr;
  logic             r_done;

  logic             w_accept;
  logic             w_bit_end;
  logic             w_txd_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  assign w_bit_end = (r_cnt == LAST_CNT);

  // State register, shadow copy of the request, and the registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shadow   <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_clr      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      if (w_accept) begin
        r_shadow   <= bus.txData;
        r_par_en   <= bus.parityEn;
        r_par_odd  <= bus.parityOdd;
        r_two_stop <= bus.twoStop;
      end
      r_txd  <= w_txd_nxt;
      r_busy <= w_busy_nxt;
      r_clr  <= w_accept;
      r_done <= w_done_nxt;
    end
  end

  // Next state: r_bit_idx walks the data bits in DATA and counts stop bits in STOP.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_accept      = 1'b0;

    if (r_state == S_IDLE) begin
      w_cnt_nxt     = '0;
      w_bit_idx_nxt = '0;
      if (bus.txStart) begin
        w_accept    = 1'b1;
        w_state_nxt = S_START;
      end
    end else if (!w_bit_end) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else begin
      w_cnt_nxt = '0;
      case (r_state)
        S_START: begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
        S_DATA: begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = r_par_en ? S_PARITY : S_STOP;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
        S_PARITY: begin
          w_state_nxt   = S_STOP;
          w_bit_idx_nxt = '0;
        end
        S_STOP: begin
          if (r_two_stop && (r_bit_idx == 3'd0)) begin
            w_bit_idx_nxt = 3'd1;
          end else begin
            w_state_nxt   = S_IDLE;
            w_bit_idx_nxt = '0;
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_bit_idx_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = r_shadow[w_bit_idx_nxt];
      S_PARITY: w_txd_nxt = (^r_shadow) ^ r_par_odd;
      default:  w_txd_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_STOP) && (w_cnt_nxt == LAST_CNT) &&
                 (w_bit_idx_nxt[0] == r_two_stop);
  end

  assign bus.txd           = r_txd;
  assign bus.busy          = r_busy;
  assign bus.clrTxStartBit = r_clr;
  assign bus.txDone        = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus queues expected frames, a line
// monitor decodes txd cycle by cycle and compares against a bit-list model.
module tb_uart_tx_frame;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_frame_if bus ();

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       po;
    logic       ts;
    bit         b2b;
    bit         abort;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_in_frame = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Parity from the spec's rule: even parity makes the total count of ones even.
  function automatic logic model_parity(input logic [7:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic po,
                      input logic ts, input bit abort);
    exp_t e;
    wait_idle();
    bus.txData    = d;
    bus.parityEn  = pe;
    bus.parityOdd = po;
    bus.twoStop   = ts;
    bus.txStart   = 1'b1;
    e = '{data: d, pe: pe, po: po, ts: ts, b2b: 1'b0, abort: abort};
    sb.push_back(e);
    @(posedge clk); #1;
    bus.txStart   = 1'b0;
    bus.txData    = 8'($urandom);
    bus.parityEn  = 1'($urandom);
    bus.parityOdd = 1'($urandom);
    bus.twoStop   = 1'($urandom);
  endtask

  // Line monitor: acts as the downstream receiver and scoreboard checker.
  initial begin : monitor
    exp_t       e;
    int         nbits, last, last_end, k, n;
    int         err_txd, err_busy, err_clr, n_done, done_at;
    logic       fb [12];
    logic       rxb [12];
    logic [7:0] rx_byte;
    bit         aborted;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.txd === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'(bus.txd), 32'd1);
          n = 0;
          while (bus.txd === 1'b0 && n < 4000) begin @(negedge clk); n++; end
        end else begin
          mon_in_frame = 1'b1;
          e = sb.pop_front();
          if (e.b2b) check("b2b_gap", 32'(cyc - last_end), 32'd2);
          for (int i = 0; i < 12; i++) begin fb[i] = 1'b1; rxb[i] = 1'bx; end
          fb[0] = 1'b0;
          for (int i = 0; i < 8; i++) fb[1 + i] = e.data[i];
          k = 9;
          if (e.pe) begin fb[k] = model_parity(e.data, e.po); k++; end
          nbits = 10 + int'(e.pe) + int'(e.ts);
          last  = nbits * CPB - 1;
          err_txd = 0; err_busy = 0; err_clr = 0; n_done = 0; done_at = -1;
          aborted = 1'b0;
          for (int j = 0; j <= last; j++) begin
            if (j > 0) @(negedge clk);
            if (rst !== 1'b1) begin aborted = 1'b1; break; end
            if (bus.txd !== fb[j / CPB]) err_txd++;
            if (bus.busy !== 1'b1) err_busy++;
            if (bus.clrTxStartBit !== (j == 0)) err_clr++;
            if (bus.txDone === 1'b1) begin
              n_done++;
              if (done_at < 0) done_at = j;
            end
            if ((j % CPB) == CPB / 2) rxb[j / CPB] = bus.txd;
          end
          if (aborted) begin
            if (!e.abort) check("unexpected_abort", 32'(rst), 32'd1);
            check("abort_partial_txd", 32'(err_txd), 32'd0);
            check("abort_no_done", 32'(n_done), 32'd0);
            @(negedge clk);
            check("reset_abort", 32'({bus.txd, bus.busy, bus.txDone}), 32'b100);
            n = 0;
            while (rst !== 1'b1 && n < 100) begin @(negedge clk); n++; end
          end else begin
            last_end = cyc;
            check("txd_bits", 32'(err_txd), 32'd0);
            check("busy_high", 32'(err_busy), 32'd0);
            check("clr_pulse", 32'(err_clr), 32'd0);
            check("done_count", 32'(n_done), 32'd1);
            check("done_at", 32'(done_at), 32'(last));
            for (int i = 0; i < 8; i++) rx_byte[i] = rxb[1 + i];
            check("rx_byte", 32'(rx_byte), 32'(e.data));
            if (e.pe) check("parity_bit", 32'(rxb[9]), 32'(model_parity(e.data, e.po)));
            @(negedge clk);
            check("idle_after",
                  32'({bus.txd, bus.busy, bus.txDone, bus.clrTxStartBit}), 32'b1000);
          end
          mon_in_frame = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int   bad, n;
    exp_t e;
    bus.txStart   = 1'b0;
    bus.txData    = 8'h00;
    bus.parityEn  = 1'b0;
    bus.parityOdd = 1'b0;
    bus.twoStop   = 1'b0;

    // Reset, then a quiet idle stretch.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          32'({bus.txd, bus.busy, bus.txDone, bus.clrTxStartBit}), 32'b1000);
    rst = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if ({bus.txd, bus.busy, bus.txDone, bus.clrTxStartBit} !== 4'b1000) bad++;
    end
    check("idle200", 32'(bad), 32'd0);

    // Directed frames.
    send(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // txStart held through txDone with txData changed mid-frame.
    wait_idle();
    bus.txData    = 8'h3C;
    bus.parityEn  = 1'b1;
    bus.parityOdd = 1'b0;
    bus.twoStop   = 1'b0;
    bus.txStart   = 1'b1;
    e = '{data: 8'h3C, pe: 1'b1, po: 1'b0, ts: 1'b0, b2b: 1'b0, abort: 1'b0};
    sb.push_back(e);
    e = '{data: 8'hC3, pe: 1'b1, po: 1'b0, ts: 1'b0, b2b: 1'b1, abort: 1'b0};
    sb.push_back(e);
    @(posedge clk); #1;
    bus.txData = 8'hC3;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.clrTxStartBit !== 1'b1 && n < 1000);
    bus.txStart = 1'b0;
    if (n >= 1000) check("b2b_timeout", 32'(bus.clrTxStartBit), 32'd1);

    // Reset in the middle of data bit 4, then a clean frame.
    send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (5 * CPB + CPB / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h96, 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized frames.
    for (int i = 0; i < 12; i++)
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    n = 0;
    while ((sb.size() != 0 || mon_in_frame) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue", 32'(sb.size()), 32'd0);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Transmit-side serializer of the UART APB slave. It is the stage directly upstream of the receiver's rxd input. It accepts one parallel byte per start request and drives a framed serial bitstream on txd: start bit, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits. Bit timing is derived from the system clock by an internal per-bit cycle counter, so txd is directly compatible with the 16x-oversampling receiver.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
CNT_W, 8, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
txStart  input  1  level request from the control register to send txData.
txData  input  8  byte to transmit; sampled only on acceptance.
parityEn  input  1  1 = insert a parity bit after the data bits.
parityOdd  input  1  0 = even parity (^data), 1 = odd parity (~^data); sampled on acceptance.
twoStop  input  1  1 = two stop bits; sampled on acceptance.
txd  output  1  serial line; idles high.
busy  output  1  high from acceptance until the end of the last stop bit.
clrTxStartBit  output  1  one-cycle pulse on acceptance; the register block clears txStart with it.
txDone  output  1  one-cycle pulse in the last cycle of the last stop bit.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, txd=1, busy=0, clrTxStartBit=0, txDone=0, counters=0. Reset applies mid-frame: txd returns to 1 on the next edge and the frame is abandoned without a txDone pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. If txStart==1, the block accepts the request on that edge:
  - latch txData, parityEn, parityOdd, twoStop into shadow registers;
  - go to START; clrTxStartBit=1 for exactly that one following cycle; busy=1.
- Latency: txd goes low in the first cycle after the edge on which txStart is seen high in IDLE.
- Each bit state holds txd for exactly CLKS_PER_BIT cycles. The counter counts 0..CLKS_PER_BIT-1, and the state advances when the counter reaches CLKS_PER_BIT-1.
- START: txd=0, then DATA.
- DATA: txd = shadow[bitIdx], with bitIdx running 0..7. After bit 7, go to PARITY if parityEn, else STOP.
- PARITY: txd = ^shadow XOR parityOdd, then STOP.
- STOP: txd=1 for 1 bit, or 2 bits if twoStop. In the final cycle, txDone=1 and busy stays 1. Next state is IDLE (busy=0).
- Frame length in cycles: CLKS_PER_BIT * (10 + parityEn + twoStop).
- Back-to-back: if txStart is high in the first IDLE cycle after txDone, the new start bit begins one cycle later. Exactly one idle-high cycle separates frames.
- txStart or txData changes during busy are ignored; only the latched copy is sent.
- txStart held high with no acknowledgement clear starts repeated frames; clearing it is the register block's job via clrTxStartBit.
- txd, busy, txDone and clrTxStartBit are registered outputs, with no combinational path from inputs.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1, with txStart=0 -> txd=1, busy=0, no pulses for 200 cycles.
- Send 0x10, parityEn=1, parityOdd=0, twoStop=0, CLKS_PER_BIT=16:
  - txd sequence 0,0,0,0,0,1,0,0,0,1,1, each held 16 cycles (parity bit = 1);
  - txDone at cycle 176 after acceptance;
  - clrTxStartBit high exactly 1 cycle.
- Send 0xA5 with parityEn=0, twoStop=1 -> frame is 0,1,0,1,0,0,1,0,1,1,1, totalling 176 cycles. Loop txd into uart_rx and check the received byte is 0xA5.
- Odd parity on 0xFF -> parity bit = 1. Even parity on 0xFF -> parity bit = 0.
- Change txData from 0x3C to 0xC3 mid-frame, and hold txStart high through txDone:
  - frame 1 carries 0x3C;
  - exactly one idle cycle follows, then frame 2 carries 0xC3.
- Assert rst=0 during DATA bit 4 -> txd=1, busy=0 on the next edge, with no txDone pulse. A new request after release sends a clean full frame.
